// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NREQ byte producers using round-robin arbitration.
// Each grant sends one byte. tx_datain stays stable for the whole frame, because the
// transmitter samples it bit by bit. tx_idle is the transmitter's line status:
// 1 means a frame is in progress and 0 means the line is free.
module uart_tx_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int WR_PULSE = 2,
  parameter int BUSY_TO  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_datain,
  output logic              tx_wrsig,
  input  logic              tx_idle,
  output logic [IDW-1:0]    grant_id,
  output logic              busy,
  output logic              err_to
);

  localparam int SCW = (WR_PULSE > 1) ? $clog2(WR_PULSE + 1) : 1;
  localparam int TOW = $clog2(BUSY_TO + 1);
  localparam logic [SCW-1:0] STRB_LAST = SCW'(WR_PULSE - 1);
  localparam logic [TOW-1:0] TO_LAST   = TOW'(BUSY_TO - 1);
  localparam logic [IDW-1:0] ID_LAST   = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]  grant_id_reg, grant_id_next;
  logic [7:0]      datain_reg, datain_next;
  logic            wrsig_reg, wrsig_next;
  logic [NREQ-1:0] ready_reg, ready_next;
  logic            err_reg, err_next;
  logic [SCW-1:0]  strb_cnt_reg, strb_cnt_next;
  logic [TOW-1:0]  to_cnt_reg, to_cnt_next;
  logic            seen_reg, seen_next;

  // Split the packed request bus into one byte per requester.
  logic [7:0] req_byte [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  // Round-robin search: the first valid requester at or after rr_ptr wins.
  int             cand;
  logic [IDW-1:0] cand_idx;
  logic           win_found;
  logic [IDW-1:0] win_id;

  // Combinational winner selection, starting from rr_ptr and wrapping modulo NREQ.
  always_comb begin
    cand      = 0;
    cand_idx  = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand     = (int'(rr_ptr_reg) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_id    = cand_idx;
      end
    end
  end

  // State and output registers; async active-low reset returns everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      datain_reg   <= '0;
      wrsig_reg    <= 1'b0;
      ready_reg    <= '0;
      err_reg      <= 1'b0;
      strb_cnt_reg <= '0;
      to_cnt_reg   <= '0;
      seen_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rr_ptr_reg   <= rr_ptr_next;
      grant_id_reg <= grant_id_next;
      datain_reg   <= datain_next;
      wrsig_reg    <= wrsig_next;
      ready_reg    <= ready_next;
      err_reg      <= err_next;
      strb_cnt_reg <= strb_cnt_next;
      to_cnt_reg   <= to_cnt_next;
      seen_reg     <= seen_next;
    end
  end

  // Next-state logic. The outputs are registered, so each one is computed one edge ahead
  // of the state it belongs to.
  always_comb begin
    state_next    = state_reg;
    rr_ptr_next   = rr_ptr_reg;
    grant_id_next = grant_id_reg;
    datain_next   = datain_reg;
    wrsig_next    = 1'b0;
    ready_next    = '0;
    err_next      = 1'b0;
    strb_cnt_next = strb_cnt_reg;
    to_cnt_next   = to_cnt_reg;
    seen_next     = seen_reg;

    case (state_reg)
      S_IDLE: begin
        // Grant only when the line is free. A 1 on tx_idle means another source owns
        // the transmitter.
        if (!tx_idle && win_found) begin
          grant_id_next = win_id;
          datain_next   = req_byte[win_id];
          ready_next    = NREQ'(1) << win_id;
          rr_ptr_next   = (win_id == ID_LAST) ? '0 : win_id + IDW'(1);
          wrsig_next    = 1'b1;
          strb_cnt_next = '0;
          to_cnt_next   = '0;
          seen_next     = 1'b0;
          state_next    = S_STROBE;
        end
      end

      S_STROBE: begin
        // The timeout counter starts at the wrsig rise, so it already runs during the
        // strobe. A fast core may report busy before the strobe has finished.
        to_cnt_next = to_cnt_reg + TOW'(1);
        seen_next   = seen_reg | tx_idle;
        if (strb_cnt_reg == STRB_LAST) begin
          wrsig_next = 1'b0;
          state_next = (seen_reg || tx_idle) ? S_WAIT_DONE : S_WAIT_BUSY;
        end else begin
          strb_cnt_next = strb_cnt_reg + SCW'(1);
          wrsig_next    = 1'b1;
        end
      end

      S_WAIT_BUSY: begin
        to_cnt_next = to_cnt_reg + TOW'(1);
        if (tx_idle) begin
          state_next = S_WAIT_DONE;
        end else if (to_cnt_reg == TO_LAST) begin
          // The core never started a frame, so the byte is dropped. rr_ptr has already
          // moved past this requester.
          err_next   = 1'b1;
          state_next = S_IDLE;
        end
      end

      S_WAIT_DONE: begin
        if (!tx_idle) begin
          state_next = S_GAP;
        end
      end

      S_GAP: begin
        // A single low cycle so that the next grant produces a clean rising edge.
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign req_ready = ready_reg;
  assign tx_datain = datain_reg;
  assign tx_wrsig  = wrsig_reg;
  assign grant_id  = grant_id_reg;
  assign err_to    = err_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. It contains a cycle-based model of the UART core, a
// monitor that logs every grant, and a scoreboard of expected grants and serial bits.
module tb_uart_tx_arbiter;

  localparam int IDLE_LAT = 4;
  localparam int BITC     = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_datain;
  logic        tx_wrsig;
  logic        tx_idle;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_to;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
  } gnt_t;

  gnt_t obs_q[$];
  gnt_t exp_q[$];
  logic ser_q[$];
  logic exp_ser_q[$];

  int bad_onehot  = 0;
  int err_cnt     = 0;
  int overlap_cnt = 0;

  // UART core model: tx_idle either comes from the model or is forced by the bench.
  logic uart_en    = 1'b0;
  logic force_idle = 1'b0;
  logic model_idle;
  logic m_active;
  logic wr_prev;
  int   m_cnt;
  int   frame_len = 169;

  assign tx_idle = uart_en ? model_idle : force_idle;

  uart_tx_arbiter #(
    .NREQ(4), .IDW(2), .WR_PULSE(2), .BUSY_TO(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_datain(tx_datain), .tx_wrsig(tx_wrsig),
    .tx_idle(tx_idle), .grant_id(grant_id), .busy(busy), .err_to(err_to)
  );

  always #5 clk = ~clk;

  // UART model: the line goes busy IDLE_LAT cycles after the wrsig rise and stays busy
  // for frame_len cycles. It samples tx_datain in the middle of each bit period.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_idle <= 1'b0;
      m_active   <= 1'b0;
      wr_prev    <= 1'b0;
      m_cnt      <= 0;
    end else begin
      wr_prev <= tx_wrsig;
      if (uart_en && tx_wrsig && !wr_prev) begin
        if (m_active) overlap_cnt <= overlap_cnt + 1;
        else begin
          m_active <= 1'b1;
          m_cnt    <= 1;
        end
      end else if (m_active) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == IDLE_LAT) model_idle <= 1'b1;
        for (int b = 0; b < 9; b++) begin
          if (m_cnt + 1 == IDLE_LAT + b * BITC + BITC / 2)
            ser_q.push_back((b == 0) ? 1'b0 : tx_datain[b-1]);
        end
        if (m_cnt + 1 == IDLE_LAT + frame_len) begin
          model_idle <= 1'b0;
          m_active   <= 1'b0;
        end
      end
    end
  end

  // Grant monitor: prints one line per captured byte and logs it for the scoreboard.
  always @(negedge clk) begin
    if (rst_n && req_ready != 4'b0000) begin
      gnt_t g;
      g.id = -1;
      for (int i = 3; i >= 0; i--) if (req_ready[i]) g.id = i;
      if ($countones(req_ready) != 1) bad_onehot++;
      g.data = tx_datain;
      obs_q.push_back(g);
      $display("grant id=%0d data=0x%02h grant_id=%0d t=%0t", g.id, g.data, grant_id, $time);
    end
    if (rst_n && err_to) err_cnt++;
  end

  function automatic int ref_pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete(); exp_q.delete(); ser_q.delete(); exp_ser_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; #1;
    checks++; if (tx_wrsig !== 1'b0) begin errors++; $display("FAIL reset_wrsig: got %b expected 0", tx_wrsig); end
    checks++; if (tx_datain !== 8'h00) begin errors++; $display("FAIL reset_datain: got %h expected 00", tx_datain); end
    checks++; if (req_ready !== 4'h0) begin errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL reset_err_to: got %b expected 0", err_to); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single_byte();
    int n;
    int bad;
    logic [7:0] b;
    do_reset();
    uart_en = 1'b1; frame_len = 169;
    b = 8'hA5;
    req_data[23:16] = b;
    exp_ser_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_ser_q.push_back(b[i]);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d expected 2", grant_id); end
    checks++; if (tx_wrsig !== 1'b1) begin errors++; $display("FAIL single_wrsig_c1: got %b expected 1", tx_wrsig); end
    checks++; if (tx_datain !== 8'hA5) begin errors++; $display("FAIL single_datain: got %h expected a5", tx_datain); end
    req_valid = '0;
    @(negedge clk);
    checks++; if ({req_ready, tx_wrsig} !== 5'b0000_1) begin errors++; $display("FAIL single_wrsig_c2: got ready=%b wrsig=%b expected 0000/1", req_ready, tx_wrsig); end
    @(negedge clk);
    checks++; if (tx_wrsig !== 1'b0) begin errors++; $display("FAIL single_wrsig_c3: got %b expected 0", tx_wrsig); end
    n = 0; bad = 0;
    while (busy === 1'b1 && n < 400) begin
      if (tx_datain !== 8'hA5 || tx_wrsig !== 1'b0) bad++;
      @(negedge clk); n++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_frame_end: busy got %b expected 0 after %0d cycles", busy, n); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL single_hold: got %0d bad cycles expected 0", bad); end
    checks++; if (ser_q.size() !== exp_ser_q.size()) begin errors++; $display("FAIL single_serial_len: got %0d expected %0d", ser_q.size(), exp_ser_q.size()); end
    while (ser_q.size() > 0 && exp_ser_q.size() > 0) begin
      logic got, want;
      got = ser_q.pop_front(); want = exp_ser_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL single_serial_bit: got %b expected %b", got, want); end
    end
  endtask

  task automatic test_round_robin();
    int n, p, id, ov0;
    do_reset();
    uart_en = 1'b1; frame_len = 30;
    req_data = 32'h13121110;
    ov0 = overlap_cnt;
    p = 0;
    repeat (5) begin
      gnt_t e;
      id = ref_pick(4'hF, p);
      e.id = id; e.data = 8'h10 + 8'(id);
      exp_q.push_back(e);
      p = (id + 1) % 4;
    end
    req_valid = 4'hF;
    n = 0;
    while (obs_q.size() < 5 && n < 2000) begin @(negedge clk); n++; end
    req_valid = '0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (obs_q.size() !== 5) begin errors++; $display("FAIL rr_count: got %0d grants expected 5", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      gnt_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o.id !== e.id || o.data !== e.data) begin errors++; $display("FAIL rr_grant: got id=%0d data=%h expected id=%0d data=%h", o.id, o.data, e.id, e.data); end
    end
    checks++; if (overlap_cnt - ov0 !== 0) begin errors++; $display("FAIL rr_wrsig_while_busy: got %0d expected 0", overlap_cnt - ov0); end
    checks++; if (bad_onehot !== 0) begin errors++; $display("FAIL rr_onehot: got %0d bad pulses expected 0", bad_onehot); end
  endtask

  task automatic test_timeout();
    int early, n;
    gnt_t e;
    do_reset();
    uart_en = 1'b0; force_idle = 1'b0;
    req_data[15:8] = 8'h3C; req_data[23:16] = 8'h77; req_data[7:0] = 8'h55;
    e.id = 1; e.data = 8'h3C; exp_q.push_back(e);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_ready: got %b expected 0010", req_ready); end
    req_valid = 4'b0101;
    e.id = ref_pick(4'b0101, 2); e.data = (e.id == 2) ? 8'h77 : 8'h55; exp_q.push_back(e);
    early = 0;
    for (int j = 1; j < 16; j++) begin
      @(negedge clk);
      if (err_to !== 1'b0) early++;
    end
    checks++; if (early !== 0) begin errors++; $display("FAIL to_early: got %0d early pulses expected 0", early); end
    @(negedge clk);
    checks++; if (err_to !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b expected 1", err_to); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_back_idle: busy got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (err_to !== 1'b0) begin errors++; $display("FAIL to_pulse_width: got %b expected 0", err_to); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL to_next_grant: got %b expected 0100", req_ready); end
    req_valid = '0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin @(negedge clk); n++; end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      gnt_t o, x;
      o = obs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (o.id !== x.id || o.data !== x.data) begin errors++; $display("FAIL to_grant: got id=%0d data=%h expected id=%0d data=%h", o.id, o.data, x.id, x.data); end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL to_missing: got %0d unmatched expected 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    do_reset();
    uart_en = 1'b1; frame_len = 169;
    req_data[23:16] = 8'hC3; req_data[31:24] = 8'hE1; req_data[7:0] = 8'h5A;
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = '0;
    repeat (79) @(negedge clk);
    checks++; if (busy !== 1'b1 || tx_datain !== 8'hC3) begin errors++; $display("FAIL rmid_in_frame: got busy=%b data=%h expected 1/c3", busy, tx_datain); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({tx_wrsig, busy, err_to} !== 3'b000) begin errors++; $display("FAIL rmid_async_ctrl: got %b expected 000", {tx_wrsig, busy, err_to}); end
    checks++; if (tx_datain !== 8'h00 || grant_id !== 2'd0) begin errors++; $display("FAIL rmid_async_data: got data=%h id=%0d expected 00/0", tx_datain, grant_id); end
    req_valid = 4'b1001;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001 || tx_datain !== 8'h5A) begin errors++; $display("FAIL rmid_first_grant: got ready=%b data=%h expected 0001/5a", req_ready, tx_datain); end
    req_valid = '0;
    n = 0;
    while (busy === 1'b1 && n < 400) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_frame_end: busy got %b expected 0", busy); end
  endtask

  task automatic test_drop_before_grant();
    int n, e0;
    gnt_t e;
    do_reset();
    uart_en = 1'b1; frame_len = 30;
    req_data = 32'h33224444;
    req_data[7:0] = 8'h44;
    e0 = err_cnt;
    req_valid = 4'b0100;
    e.id = 2; e.data = 8'h22; exp_q.push_back(e);
    @(negedge clk);
    req_valid = 4'b1001;
    e.id = ref_pick(4'b0001, 3); e.data = 8'h44; exp_q.push_back(e);
    n = 0;
    while (tx_idle !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (tx_idle !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL drop_frame_end: tx_idle got %b expected 0", tx_idle); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_gap: busy got %b expected 1", busy); end
    req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL drop_idle_cycle: got %b expected 0000", req_ready); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL drop_grant0: got %b expected 0001", req_ready); end
    req_valid = '0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL drop_count: got %0d grants expected 2", obs_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      gnt_t o, x;
      o = obs_q.pop_front(); x = exp_q.pop_front();
      checks++; if (o.id !== x.id || o.data !== x.data) begin errors++; $display("FAIL drop_grant: got id=%0d data=%h expected id=%0d data=%h", o.id, o.data, x.id, x.data); end
    end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL drop_err_to: got %0d pulses expected 0", err_cnt - e0); end
  endtask

  task automatic test_idle_hold();
    int act, n;
    uart_en = 1'b0; force_idle = 1'b1;
    rst_n = 1'b0;
    req_data[15:8] = 8'h99;
    req_valid = 4'b0010;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || req_ready !== 4'b0000) act++;
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL hold_no_grant: got %0d active cycles expected 0", act); end
    force_idle = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin errors++; $display("FAIL hold_grant: got ready=%b id=%0d expected 0010/1", req_ready, grant_id); end
    checks++; if (tx_datain !== 8'h99 || tx_wrsig !== 1'b1) begin errors++; $display("FAIL hold_data: got data=%h wrsig=%b expected 99/1", tx_datain, tx_wrsig); end
    req_valid = '0;
    n = 0;
    while (busy === 1'b1 && n < 60) begin @(negedge clk); n++; end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_round_robin();
    test_timeout();
    test_reset_mid_frame();
    test_drop_before_grant();
    test_idle_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
